// File: rtl/program_receiver.sv
// Receiving end of the program stream: buffers {x, y, data} words in a FIFO,
// drains them as render-memory writes and pulses resume once per completed batch.
module program_receiver #(
  parameter int BATCH_LEN  = 35,
  parameter int FIFO_DEPTH = 64,
  parameter int X_W        = 11,
  parameter int Y_W        = 12,
  parameter int D_W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               program_in,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [D_W-1:0]     data_in,
  output logic               mem_we,
  output logic [X_W+Y_W-1:0] mem_addr,
  output logic [D_W-1:0]     mem_wdata,
  input  logic               mem_ready,
  output logic               resume,
  output logic               overflow,
  output logic [15:0]        batch_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int A_W = X_W + Y_W;
  localparam int E_W = A_W + D_W;
  localparam int CW  = $clog2(2 * BATCH_LEN + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BATCH_C = CW'(BATCH_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(2 * BATCH_LEN);

  typedef enum logic [1:0] {COLLECT, DRAIN, RESUME} state_t;

  state_t         state;
  logic [E_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, rd_next;
  logic [AW:0]    count, count_after_pop, count_next;
  logic [CW-1:0]  word_cnt, wr_cnt, word_next, wr_next;
  logic [E_W-1:0] entry_in, head_next;
  logic           full, pop, push, batch_done;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic inc);
    if (inc && c != CNT_MAX) return c + CW'(1);
    return c;
  endfunction

  always_comb begin
    entry_in        = {y_in, x_in, data_in};
    full            = (count == DEPTH_C);
    pop             = mem_we && mem_ready;
    // A pop frees the slot first, so a full FIFO can still take a word in the same cycle.
    push            = program_in && (!full || pop);
    rd_next         = rd_ptr + AW'(pop);
    count_after_pop = count - (AW+1)'(pop);
    count_next      = count_after_pop + (AW+1)'(push);
    head_next       = (count_after_pop == '0) ? entry_in : fifo_mem[rd_next];
    word_next       = sat_inc(word_cnt, program_in);
    wr_next         = sat_inc(wr_cnt, pop);
    // Dropped words never get written, so an emptied FIFO also closes a full batch.
    batch_done      = (wr_next >= BATCH_C) || (count_next == '0 && word_next >= BATCH_C);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      word_cnt    <= '0;
      wr_cnt      <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      resume      <= 1'b0;
      overflow    <= 1'b0;
      batch_count <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_next;
      count    <= count_next;
      mem_we   <= (count_next != '0);
      if (count_next != '0) begin
        mem_addr  <= head_next[E_W-1:D_W];
        mem_wdata <= head_next[D_W-1:0];
      end
      if (program_in && !push) overflow <= 1'b1;
      resume   <= 1'b0;
      word_cnt <= word_next;
      wr_cnt   <= wr_next;
      case (state)
        COLLECT, DRAIN: begin
          if (batch_done) begin
            state       <= RESUME;
            resume      <= 1'b1;
            batch_count <= batch_count + 16'd1;
            word_cnt    <= (word_next >= BATCH_C) ? word_next - BATCH_C : '0;
            wr_cnt      <= (wr_next >= BATCH_C) ? wr_next - BATCH_C : '0;
          end else if (state == COLLECT && word_next >= BATCH_C) begin
            state <= DRAIN;
          end
        end
        RESUME:  state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
